// File: rtl/dma_desc_processor_pkg.sv
// Shared constants and types for the DMA descriptor processor.
package dma_desc_processor_pkg;

  // Bus beat size; descriptor addresses are aligned to this.
  localparam int BEAT_BYTES = 32;

  // Command field widths pushed into the read/write command FIFOs.
  localparam int ADDR_W = 32;
  localparam int BCNT_W = 16;

  // Descriptor sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dma_desc_processor.sv
// DMA descriptor processor: splits one {src, dst, len} descriptor into
// chunks of at most MAX_CHUNK_BYTES and pushes each chunk as a paired
// read/write command. Pulses desc_done_o once per descriptor.
module dma_desc_processor
  import dma_desc_processor_pkg::*;
#(
  parameter int LEN_W           = 24,
  parameter int MAX_CHUNK_BYTES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              desc_valid_i,
  output logic              desc_ready_o,
  input  logic [ADDR_W-1:0] desc_src_addr_i,
  input  logic [ADDR_W-1:0] desc_dst_addr_i,
  input  logic [LEN_W-1:0]  desc_len_i,
  output logic              dma_rd_fifo_command_req_o,
  output logic [BCNT_W-1:0] dma_rd_bytes_to_transfer_o,
  output logic [ADDR_W-1:0] dma_rd_addr_o,
  input  logic              dma_rd_fifo_full_i,
  output logic              dma_wr_fifo_command_req_o,
  output logic [BCNT_W-1:0] dma_wr_bytes_to_transfer_o,
  output logic [ADDR_W-1:0] dma_wr_addr_o,
  input  logic              dma_wr_fifo_full_i,
  output logic              desc_busy_o,
  output logic              desc_done_o
);

  // Next chunk size: the remainder, capped at the maximum command size.
  function automatic logic [BCNT_W-1:0] f_chunk(input logic [LEN_W-1:0] rem);
    logic [31:0] w_rem;
    w_rem = 32'(rem);
    if (w_rem > 32'(MAX_CHUNK_BYTES)) begin
      return BCNT_W'(MAX_CHUNK_BYTES);
    end
    return BCNT_W'(w_rem);
  endfunction

  state_t            r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_rem;
  logic [BCNT_W-1:0] r_chunk;
  logic              r_rd_req;
  logic              r_wr_req;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [BCNT_W-1:0] r_rd_bytes;
  logic [BCNT_W-1:0] r_wr_bytes;
  logic              r_done;

  logic              w_both_free;
  logic              w_last_chunk;

  // Both command FIFOs must have room before a pair is pushed; the chunk
  // in hand is the last one when it consumes all of the remainder.
  always_comb begin
    w_both_free  = !dma_rd_fifo_full_i && !dma_wr_fifo_full_i;
    w_last_chunk = (r_rem == LEN_W'(r_chunk));
  end

  // Descriptor FSM with its address/length datapath and registered commands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_src      <= '0;
      r_dst      <= '0;
      r_rem      <= '0;
      r_chunk    <= '0;
      r_rd_req   <= 1'b0;
      r_wr_req   <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_addr  <= '0;
      r_rd_bytes <= '0;
      r_wr_bytes <= '0;
      r_done     <= 1'b0;
    end else begin
      r_rd_req <= 1'b0;
      r_wr_req <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (desc_valid_i) begin
            r_src   <= desc_src_addr_i;
            r_dst   <= desc_dst_addr_i;
            r_rem   <= desc_len_i;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_chunk <= f_chunk(r_rem);
          r_state <= (r_rem == '0) ? ST_DONE : ST_ISSUE;
        end
        ST_ISSUE: begin
          // Hold here with requests low until both FIFOs can take the pair.
          if (w_both_free) begin
            r_rd_req   <= 1'b1;
            r_wr_req   <= 1'b1;
            r_rd_addr  <= r_src;
            r_wr_addr  <= r_dst;
            r_rd_bytes <= r_chunk;
            r_wr_bytes <= r_chunk;
            r_src      <= r_src + ADDR_W'(r_chunk);
            r_dst      <= r_dst + ADDR_W'(r_chunk);
            r_rem      <= r_rem - LEN_W'(r_chunk);
            r_state    <= w_last_chunk ? ST_DONE : ST_CALC;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Handshake/status decode and output mapping.
  always_comb begin
    desc_ready_o               = (r_state == ST_IDLE);
    desc_busy_o                = (r_state != ST_IDLE);
    desc_done_o                = r_done;
    dma_rd_fifo_command_req_o  = r_rd_req;
    dma_rd_addr_o              = r_rd_addr;
    dma_rd_bytes_to_transfer_o = r_rd_bytes;
    dma_wr_fifo_command_req_o  = r_wr_req;
    dma_wr_addr_o              = r_wr_addr;
    dma_wr_bytes_to_transfer_o = r_wr_bytes;
  end

endmodule

// File: tb/tb_dma_desc_processor.sv
// Scoreboard testbench for dma_desc_processor: a behavioural model splits
// each accepted descriptor into expected command/done events; a monitor
// compares DUT outputs against them as they appear.
module tb_dma_desc_processor;

  localparam int LEN_W = 24;
  localparam int MAXC  = 1024;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              desc_valid = 1'b0;
  logic              desc_ready;
  logic [31:0]       desc_src = '0;
  logic [31:0]       desc_dst = '0;
  logic [LEN_W-1:0]  desc_len = '0;
  logic              rd_req;
  logic [15:0]       rd_bytes;
  logic [31:0]       rd_addr;
  logic              rd_full = 1'b0;
  logic              wr_req;
  logic [15:0]       wr_bytes;
  logic [31:0]       wr_addr;
  logic              wr_full = 1'b0;
  logic              busy;
  logic              done;

  dma_desc_processor #(.LEN_W(LEN_W), .MAX_CHUNK_BYTES(MAXC)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .desc_valid_i               (desc_valid),
    .desc_ready_o               (desc_ready),
    .desc_src_addr_i            (desc_src),
    .desc_dst_addr_i            (desc_dst),
    .desc_len_i                 (desc_len),
    .dma_rd_fifo_command_req_o  (rd_req),
    .dma_rd_bytes_to_transfer_o (rd_bytes),
    .dma_rd_addr_o              (rd_addr),
    .dma_rd_fifo_full_i         (rd_full),
    .dma_wr_fifo_command_req_o  (wr_req),
    .dma_wr_bytes_to_transfer_o (wr_bytes),
    .dma_wr_addr_o              (wr_addr),
    .dma_wr_fifo_full_i         (wr_full),
    .desc_busy_o                (busy),
    .desc_done_o                (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] bytes;
  } ev_t;

  ev_t exp_q[$];
  int  req_cyc_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;
  int  n_req = 0;
  int  n_done = 0;
  int  last_done_cyc = -1;
  logic smp_rd_full = 1'b0;
  logic smp_wr_full = 1'b0;
  logic prev_req = 1'b0;
  bit   rnd_full = 1'b0;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    smp_rd_full <= rd_full;
    smp_wr_full <= wr_full;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: byte-level split of a descriptor into chunk commands.
  task automatic model_push(input logic [31:0] src, input logic [31:0] dst, input int len);
    int rem;
    int c;
    ev_t e;
    rem = len;
    while (rem > 0) begin
      c = (rem > MAXC) ? MAXC : rem;
      e.is_done = 1'b0;
      e.src     = src;
      e.dst     = dst;
      e.bytes   = 16'(c);
      exp_q.push_back(e);
      src = src + 32'(c);
      dst = dst + 32'(c);
      rem = rem - c;
    end
    e.is_done = 1'b1;
    e.src     = '0;
    e.dst     = '0;
    e.bytes   = '0;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every command pair and done pulse with the model.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 1'b0;
      end else begin
        if (rd_req || wr_req) begin
          check("req_pair", 32'(wr_req), 32'(rd_req));
          check("req_back_to_back", 32'(prev_req), 32'd0);
          check("req_while_full", 32'(smp_rd_full | smp_wr_full), 32'd0);
          n_req++;
          req_cyc_q.push_back(cyc);
          n_checks++;
          if (exp_q.size() == 0 || exp_q[0].is_done) begin
            n_errors++;
            $display("FAIL unexpected_req actual rd_addr=0x%0h bytes=%0d required no command", rd_addr, rd_bytes);
          end else begin
            e = exp_q.pop_front();
            check("rd_addr", rd_addr, e.src);
            check("wr_addr", wr_addr, e.dst);
            check("rd_bytes", 32'(rd_bytes), 32'(e.bytes));
            check("wr_bytes", 32'(wr_bytes), 32'(e.bytes));
          end
        end
        if (done) begin
          n_done++;
          last_done_cyc = cyc;
          n_checks++;
          if (exp_q.size() == 0 || !exp_q[0].is_done) begin
            n_errors++;
            $display("FAIL unexpected_done actual pending=%0d required done event at queue head", exp_q.size());
          end else begin
            void'(exp_q.pop_front());
          end
        end
        prev_req = rd_req | wr_req;
      end
    end
  end

  // One cycle of stimulus time; optionally randomizes the FIFO full flags.
  task automatic tick();
    @(negedge clk);
    #1;
    if (rnd_full) begin
      rd_full = ($urandom_range(0, 3) == 0);
      wr_full = ($urandom_range(0, 3) == 0);
    end
  endtask

  // Offer a descriptor and wait for acceptance; returns the accept cycle.
  task automatic send(input logic [31:0] src, input logic [31:0] dst, input int len,
                      input bit keep_valid, output int acc);
    int n;
    desc_valid = 1'b1;
    desc_src   = src;
    desc_dst   = dst;
    desc_len   = LEN_W'(len);
    n = 0;
    while (!desc_ready && n < 3000) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= 3000) begin
      n_errors++;
      $display("FAIL accept_timeout actual ready=%0b required ready=1", desc_ready);
    end
    model_push(src, dst, len);
    tick();
    acc = cyc;
    if (!keep_valid) desc_valid = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (n_done <= base && n < 3000) begin
      tick();
      n++;
    end
    check("done_seen", 32'(n_done > base), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !desc_ready) && n < 20000) begin
      tick();
      n++;
    end
    check("idle_pending_events", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int acc;
    int acc2;
    int base;
    int x;
    int n;
    logic [31:0] s;
    logic [31:0] d;
    int len;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 32'(desc_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_wr_req", 32'(wr_req), 32'd0);
    check("rst_rd_addr", rd_addr, 32'd0);
    reset = 1'b0;
    tick();

    // Basic split: 2500 bytes -> 1024, 1024, 452
    req_cyc_q.delete();
    base = n_done;
    send(32'h1000, 32'h8000, 2500, 1'b0, acc);
    check("busy_after_accept", 32'(busy), 32'd1);
    wait_done(base);
    check("t1_npairs", 32'(req_cyc_q.size()), 32'd3);
    if (req_cyc_q.size() == 3) begin
      check("t1_first_req_latency", 32'(req_cyc_q[0] - acc), 32'd2);
      check("t1_pair_spacing", 32'(req_cyc_q[1] - req_cyc_q[0]), 32'd2);
      check("t1_done_after_last", 32'(last_done_cyc - req_cyc_q[2]), 32'd1);
    end
    tick();

    // Zero length: no commands, done two cycles after accept
    req_cyc_q.delete();
    base = n_done;
    send(32'h2000, 32'h3000, 0, 1'b0, acc);
    wait_done(base);
    check("t2_no_req", 32'(req_cyc_q.size()), 32'd0);
    check("t2_done_latency", 32'(last_done_cyc - acc), 32'd2);
    check("t2_ready_back", 32'(desc_ready), 32'd1);
    tick();

    // Exactly one maximum chunk
    req_cyc_q.delete();
    base = n_done;
    send(32'h0004_0000, 32'h0005_0000, 1024, 1'b0, acc);
    wait_done(base);
    check("t3_npairs", 32'(req_cyc_q.size()), 32'd1);
    if (req_cyc_q.size() == 1)
      check("t3_done_after_req", 32'(last_done_cyc - req_cyc_q[0]), 32'd1);
    tick();

    // Back-pressure from each FIFO in turn
    for (int k = 0; k < 2; k++) begin
      req_cyc_q.delete();
      base = n_done;
      if (k == 0) rd_full = 1'b1; else wr_full = 1'b1;
      send(32'h0000_A000 + 32'(k * 32'h1000), 32'h0000_C000, 1024, 1'b0, acc);
      repeat (12) tick();
      check(k == 0 ? "t4_rd_full_no_req" : "t4_wr_full_no_req", 32'(req_cyc_q.size()), 32'd0);
      x = cyc;
      rd_full = 1'b0;
      wr_full = 1'b0;
      tick();
      check("t4_release_req", 32'(req_cyc_q.size()), 32'd1);
      if (req_cyc_q.size() > 0)
        check("t4_release_latency", 32'(req_cyc_q[0] - x), 32'd1);
      wait_done(base);
      tick();
    end

    // Reset in the middle of a descriptor
    req_cyc_q.delete();
    send(32'h0010_0000, 32'h0020_0000, 4096, 1'b0, acc);
    n = 0;
    while (req_cyc_q.size() == 0 && n < 100) begin
      tick();
      n++;
    end
    check("t5_first_chunk", 32'(req_cyc_q.size()), 32'd1);
    tick();
    #2;
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("t5_async_rd_req", 32'(rd_req), 32'd0);
    check("t5_async_wr_req", 32'(wr_req), 32'd0);
    check("t5_async_rd_addr", rd_addr, 32'd0);
    check("t5_async_wr_bytes", 32'(wr_bytes), 32'd0);
    check("t5_async_busy", 32'(busy), 32'd0);
    check("t5_async_ready", 32'(desc_ready), 32'd1);
    tick();
    reset = 1'b0;
    base = n_req;
    repeat (30) tick();
    check("t5_no_more_req", 32'(n_req - base), 32'd0);
    check("t5_ready", 32'(desc_ready), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);

    // Two descriptors back to back with valid held
    base = n_done;
    send(32'h0030_0000, 32'h0040_0000, 2100, 1'b1, acc);
    send(32'h0050_0000, 32'h0060_0000, 1100, 1'b0, acc2);
    check("t6_second_accept", 32'(acc2 - last_done_cyc), 32'd1);
    wait_done(base + 1);
    tick();

    // Randomized descriptors with random FIFO back-pressure
    rnd_full = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s = $urandom & 32'hFFFF_FFE0;
      d = $urandom & 32'hFFFF_FFE0;
      case ($urandom_range(0, 5))
        0:       len = 0;
        1:       len = MAXC * $urandom_range(1, 4);
        2:       len = $urandom_range(1, 40);
        default: len = $urandom_range(1, 5000);
      endcase
      if (i == 7) s = 32'hFFFF_FE00;
      send(s, d, len, 1'b0, acc);
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle();
    rnd_full = 1'b0;
    rd_full  = 1'b0;
    wr_full  = 1'b0;
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
